// File: rtl/reset_sequencer.sv
// Reset sequencer: PLL-lock filtered, staged sys/usb/disk reset release
// with watchdog/software fault hold and last-reset-cause capture.
module reset_sequencer #(
   parameter int LOCK_FILTER = 8,
   parameter int STAGE_DELAY = 16,
   parameter int FAULT_HOLD  = 32
) (
   input  logic       clk_ref,
   input  logic       rst_ext_n,
   input  logic       pll_locked,
   input  logic       wdt_reset,
   input  logic       sw_reset_req,
   input  logic       cause_clr,
   output logic       rst_sys_n,
   output logic       rst_usb_n,
   output logic       rst_disk_n,
   output logic       seq_done,
   output logic [1:0] reset_cause
);

   typedef enum logic [2:0] {
      LOCK_WAIT = 3'd0,
      REL_SYS   = 3'd1,
      REL_USB   = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } state_t;

   localparam int M1 = (LOCK_FILTER > STAGE_DELAY) ?
                       LOCK_FILTER : STAGE_DELAY;
   localparam int CMAX = (M1 > FAULT_HOLD) ? M1 : FAULT_HOLD;
   localparam int CW = $clog2(CMAX + 1);

   localparam logic [CW-1:0] LF_T  = CW'(LOCK_FILTER - 1);
   localparam logic [CW-1:0] SD_T  = CW'(STAGE_DELAY - 1);
   localparam logic [CW-1:0] FH_T  = CW'(FAULT_HOLD - 1);
   localparam logic [CW-1:0] C_SAT = CW'(CMAX);

   logic          r_lock_m;
   logic          r_lock_s;
   logic          r_wdt_m;
   logic          r_wdt_s;
   logic          r_wdt_d;
   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_cause;
   logic          r_sys_n;
   logic          r_usb_n;
   logic          r_disk_n;
   logic          r_done;

   state_t        w_state_nx;
   logic [CW-1:0] w_cnt_nx;
   logic [CW-1:0] w_cnt_inc;
   logic [1:0]    w_cause_nx;
   logic          w_active;
   logic          w_pll_loss;
   logic          w_wdt_ev;
   logic          w_sw_ev;
   logic          w_sys_nx;
   logic          w_usb_nx;
   logic          w_disk_nx;

   always_ff @(posedge clk_ref or negedge rst_ext_n) begin
      if (!rst_ext_n) begin
         r_lock_m <= 1'b0;
         r_lock_s <= 1'b0;
         r_wdt_m  <= 1'b0;
         r_wdt_s  <= 1'b0;
         r_wdt_d  <= 1'b0;
         r_state  <= LOCK_WAIT;
         r_cnt    <= '0;
         r_cause  <= 2'b00;
         r_sys_n  <= 1'b0;
         r_usb_n  <= 1'b0;
         r_disk_n <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_lock_m <= pll_locked;
         r_lock_s <= r_lock_m;
         r_wdt_m  <= wdt_reset;
         r_wdt_s  <= r_wdt_m;
         r_wdt_d  <= r_wdt_s;
         r_state  <= w_state_nx;
         r_cnt    <= w_cnt_nx;
         r_cause  <= w_cause_nx;
         r_sys_n  <= w_sys_nx;
         r_usb_n  <= w_usb_nx;
         r_disk_n <= w_disk_nx;
         r_done   <= w_disk_nx;
      end
   end

   assign w_active = (r_state == REL_SYS) ||
                     (r_state == REL_USB) ||
                     (r_state == RUN);
   assign w_pll_loss = !r_lock_s && (r_state != LOCK_WAIT);
   assign w_wdt_ev   = w_active && r_wdt_s && !r_wdt_d;
   assign w_sw_ev    = w_active && sw_reset_req;
   assign w_cnt_inc  = (r_cnt == C_SAT) ? r_cnt : r_cnt + 1'b1;

   // Event priority: PLL loss, then watchdog, then software.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_cause_nx = cause_clr ? 2'b00 : r_cause;
      if (w_pll_loss) begin
         w_state_nx = LOCK_WAIT;
         w_cnt_nx   = '0;
         w_cause_nx = 2'b01;
      end else if (w_wdt_ev) begin
         w_state_nx = FAULT;
         w_cnt_nx   = '0;
         w_cause_nx = 2'b10;
      end else if (w_sw_ev) begin
         w_state_nx = FAULT;
         w_cnt_nx   = '0;
         w_cause_nx = 2'b11;
      end else begin
         case (r_state)
            LOCK_WAIT: begin
               if (!r_lock_s) begin
                  w_cnt_nx = '0;
               end else if (r_cnt == LF_T) begin
                  w_state_nx = REL_SYS;
                  w_cnt_nx   = '0;
               end else begin
                  w_cnt_nx = w_cnt_inc;
               end
            end
            REL_SYS: begin
               if (r_cnt == SD_T) begin
                  w_state_nx = REL_USB;
                  w_cnt_nx   = '0;
               end else begin
                  w_cnt_nx = w_cnt_inc;
               end
            end
            REL_USB: begin
               if (r_cnt == SD_T) begin
                  w_state_nx = RUN;
                  w_cnt_nx   = '0;
               end else begin
                  w_cnt_nx = w_cnt_inc;
               end
            end
            RUN: begin
               w_cnt_nx = '0;
            end
            FAULT: begin
               if (r_cnt == FH_T) begin
                  w_state_nx = LOCK_WAIT;
                  w_cnt_nx   = '0;
               end else begin
                  w_cnt_nx = w_cnt_inc;
               end
            end
            default: begin
               w_state_nx = LOCK_WAIT;
               w_cnt_nx   = '0;
            end
         endcase
      end
   end

   // Outputs decode the next state so they change on the transition edge.
   always_comb begin
      w_sys_nx  = 1'b0;
      w_usb_nx  = 1'b0;
      w_disk_nx = 1'b0;
      case (w_state_nx)
         REL_SYS: begin
            w_sys_nx = 1'b1;
         end
         REL_USB: begin
            w_sys_nx = 1'b1;
            w_usb_nx = 1'b1;
         end
         RUN: begin
            w_sys_nx  = 1'b1;
            w_usb_nx  = 1'b1;
            w_disk_nx = 1'b1;
         end
         default: begin
            w_sys_nx = 1'b0;
         end
      endcase
   end

   assign rst_sys_n   = r_sys_n;
   assign rst_usb_n   = r_usb_n;
   assign rst_disk_n  = r_disk_n;
   assign seq_done    = r_done;
   assign reset_cause = r_cause;

endmodule
